// File: rtl/bit_window_feeder_pkg.sv
// Shared constants and state type for the bit window feeder.
package bit_window_feeder_pkg;

  localparam int unsigned WIN_LEN = 4;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bit_window_feeder_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count increments, clear has priority, no wrap past all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bit_window_feeder.sv
// Serial-to-window feeder: shifts accepted bits into a 4-bit window (A oldest,
// D newest), samples the detector's Z once per new full window and counts hits.
module bit_window_feeder
  import bit_window_feeder_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             clear,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic             win_valid,
  input  logic             Z,
  output logic             hit_pulse,
  output logic [CNT_W-1:0] hit_count
);

  localparam int unsigned           FILL_W   = $clog2(WIN_LEN + 1);
  localparam logic [FILL_W-1:0]     FILL_MAX = FILL_W'(WIN_LEN);
  localparam logic [FILL_W-1:0]     FILL_PRE = FILL_W'(WIN_LEN - 1);

  logic [WIN_LEN-1:0] win_q;
  logic [FILL_W-1:0]  fill_q;
  logic               ready_q;
  logic               new_win_q;
  state_t             state_q;
  state_t             state_d;
  logic               accept;
  logic               eval;

  // ready_q keeps bit_ready low during reset and for the release cycle.
  assign bit_ready = ready_q & ~clear;
  assign accept    = bit_valid & bit_ready;
  assign win_valid = (state_q == ST_RUN);
  assign eval      = new_win_q & win_valid;

  assign A = win_q[3];
  assign B = win_q[2];
  assign C = win_q[1];
  assign D = win_q[0];

  // Ready becomes 1 on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  // FSM next state: FILL until the 4th accepted bit, then RUN until clear.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_FILL;
    end else if ((state_q == ST_FILL) && accept && (fill_q == FILL_PRE)) begin
      state_d = ST_RUN;
    end
  end

  // Window shift register, fill level, new-window flag and evaluation pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q     <= '0;
      fill_q    <= '0;
      new_win_q <= 1'b0;
      hit_pulse <= 1'b0;
    end else if (clear) begin
      win_q     <= '0;
      fill_q    <= '0;
      new_win_q <= 1'b0;
      hit_pulse <= 1'b0;
    end else begin
      if (accept) begin
        win_q <= {win_q[WIN_LEN-2:0], bit_in};
        if (fill_q != FILL_MAX) fill_q <= fill_q + 1'b1;
      end
      new_win_q <= accept && (fill_q >= FILL_PRE);
      hit_pulse <= eval & Z;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_hit_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clear),
    .inc  (eval & Z),
    .cnt  (hit_count)
  );

endmodule

// File: tb/tb_bit_window_feeder.sv
// Scoreboard bench for bit_window_feeder: two instances (CNT_W=8 and CNT_W=2)
// share the stimulus; a detector stand-in drives Z from each window.
module tb_bit_window_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       clear = 1'b0;

  logic       a1, b1, c1, d1, wv1, z1, hp1, rdy1;
  logic [7:0] cnt1;
  logic       a2, b2, c2, d2, wv2, z2, hp2, rdy2;
  logic [1:0] cnt2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Detector stand-in: Z=1 when three adjacent window bits are equal.
  function automatic logic det(input logic [3:0] w);
    return ((w[3] == w[2]) && (w[2] == w[1])) || ((w[2] == w[1]) && (w[1] == w[0]));
  endfunction

  assign z1 = det({a1, b1, c1, d1});
  assign z2 = det({a2, b2, c2, d2});

  bit_window_feeder #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(rdy1), .clear(clear), .A(a1), .B(b1), .C(c1), .D(d1),
    .win_valid(wv1), .Z(z1), .hit_pulse(hp1), .hit_count(cnt1)
  );

  bit_window_feeder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(rdy2), .clear(clear), .A(a2), .B(b2), .C(c2), .D(d2),
    .win_valid(wv2), .Z(z2), .hit_pulse(hp2), .hit_count(cnt2)
  );

  typedef struct {
    int          due;
    logic        pulse;
    int unsigned cnt;
  } exp_t;

  exp_t        sb[$];
  bit   [3:0]  bits_hist[$];
  logic [3:0]  mwin  = '0;
  int unsigned mfill = 0;
  int unsigned mcnt  = 0;
  int unsigned vis   = 0;
  logic        mready = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat2(input int unsigned n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic model_reset();
    mwin = '0; mfill = 0; mcnt = 0; vis = 0; mready = 1'b0;
    sb.delete();
  endtask

  // One cycle: drive inputs, pass the edge, then advance the reference model.
  task automatic step(input logic v, input logic b, input logic c);
    logic acc;
    bit_valid = v; bit_in = b; clear = c;
    acc = v & mready & ~c;
    @(posedge clk); #1;
    if (c) begin
      mwin = '0; mfill = 0; mcnt = 0; vis = 0;
      while (sb.size() > 0 && sb[$].due >= cyc) void'(sb.pop_back());
    end else if (acc) begin
      mwin = {mwin[2:0], b};
      if (mfill < 4) mfill++;
      if (mfill == 4) begin
        exp_t e;
        e.pulse = det(mwin);
        if (e.pulse) mcnt++;
        e.cnt = mcnt;
        e.due = cyc + 1;
        sb.push_back(e);
      end
    end
    if (rst_n) mready = 1'b1;
    bit_valid = 1'b0; clear = 1'b0;
  endtask

  // Monitor: window/ready/valid every cycle; pops the scoreboard on due cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      check("window", {a1, b1, c1, d1}, mwin);
      check("window2", {a2, b2, c2, d2}, mwin);
      check("win_valid", wv1, (mfill == 4));
      check("bit_ready", rdy1, mready & ~clear);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        vis = e.cnt;
        check("hit_pulse", hp1, e.pulse);
        check("hit_pulse2", hp2, e.pulse);
      end else begin
        check("no_pulse", hp1, 0);
        check("no_pulse2", hp2, 0);
      end
      check("hit_count", cnt1, vis);
      check("hit_count_sat", cnt2, sat2(vis));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    // Reset and release; ready follows one edge later.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_win", {a1, b1, c1, d1}, 0);
    check("rst_wv", wv1, 0);
    check("rst_cnt", cnt1, 0);
    model_reset();
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("ready_after_release", rdy1, 1);

    // 1,0,0,0 then 1,1,1 back to back.
    pat = 4'b1000;
    for (int i = 3; i >= 0; i--) step(1'b1, pat[i], 1'b0);
    check("first_window", {a1, b1, c1, d1}, 4'b1000);
    check("first_wv", wv1, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Random bits with gaps.
    for (int i = 0; i < 80; i++)
      step(($urandom_range(0, 9) < 7), 1'($urandom), 1'b0);

    // Clear in RUN, then clear after 2 accepts with bit_valid high.
    step(1'b1, 1'b1, 1'b1);
    check("clr_wv", wv1, 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("clr_fill_win", {a1, b1, c1, d1}, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom), 1'b0);
    check("refill_wv", wv1, 1);

    // Saturation: fresh count, 5+ all-ones windows.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("sat_final", cnt2, 3);
    check("unsat_final", cnt1, 6);

    // Async reset mid-RUN between edges.
    for (int i = 0; i < 6; i++) step(1'b1, 1'($urandom), 1'b0);
    bit_valid = 1'b1; bit_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_win", {a1, b1, c1, d1}, 0);
    check("async_wv", wv1, 0);
    check("async_cnt", cnt1, 0);
    check("async_pulse", hp1, 0);
    check("async_ready", rdy1, 0);
    bit_valid = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // Random with gaps and occasional clear.
    for (int i = 0; i < 150; i++)
      step(($urandom_range(0, 9) < 6), 1'($urandom), ($urandom_range(0, 29) == 0));
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
